// File: rtl/router_pkg.sv
// Shared router definitions: phase encodings and default flit width.
package router_pkg;

  localparam int unsigned DATA_WIDTH_DEFAULT = 64;

  localparam logic [2:0] PHASE_IDLE = 3'b001;
  localparam logic [2:0] PHASE_ODD  = 3'b010;
  localparam logic [2:0] PHASE_EVEN = 3'b100;

  // IDLE is left on the first edge and only re-entered through reset.
  function automatic logic [2:0] next_phase(input logic [2:0] cur);
    logic [2:0] nxt;
    case (cur)
      PHASE_IDLE: nxt = PHASE_ODD;
      PHASE_ODD:  nxt = PHASE_EVEN;
      PHASE_EVEN: nxt = PHASE_ODD;
      default:    nxt = PHASE_ODD;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: priority starts at ptr_i and ascends modulo NUM_REQ.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic               valid_o
);

  logic             found;
  logic [IDX_W-1:0] cand;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    cand  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = IDX_W'((32'(ptr_i) + i) % NUM_REQ);
      if (!found && req_i[cand]) begin
        found       = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = cand;
      end
    end
  end

  assign valid_o = found;

endmodule

// File: rtl/output_ctrl.sv
// Output port controller: two one-entry VC buffers alternating between write and link roles
// every cycle, each with its own round-robin pointer.
module output_ctrl
  import router_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEFAULT,
  parameter int unsigned NUM_REQ    = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] data_in,
  output logic [NUM_REQ-1:0]            grant,
  input  logic                          receiveO,
  output logic                          sendO,
  output logic [DATA_WIDTH-1:0]         dataO,
  output logic                          polarity
);

  localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [2:0]            state_q, state_d;
  logic                  odd_full_q, odd_full_d;
  logic                  even_full_q, even_full_d;
  logic [DATA_WIDTH-1:0] odd_data_q, odd_data_d;
  logic [DATA_WIDTH-1:0] even_data_q, even_data_d;
  logic [IdxW-1:0]       ptr_odd_q, ptr_odd_d;
  logic [IdxW-1:0]       ptr_even_q, ptr_even_d;

  logic                  is_odd, is_even, running;
  logic                  tgt_full, link_full;
  logic [DATA_WIDTH-1:0] link_data, wr_data;
  logic [IdxW-1:0]       ptr_sel, arb_idx, ptr_next;
  logic [NUM_REQ-1:0]    arb_req, arb_gnt;
  logic                  wr_en;

  assign is_odd  = (state_q == PHASE_ODD);
  assign is_even = (state_q == PHASE_EVEN);
  assign running = is_odd | is_even;

  // Write target is the buffer named by the phase; the other one faces the link.
  assign tgt_full  = is_odd ? odd_full_q : even_full_q;
  assign link_full = is_odd ? even_full_q : (is_even ? odd_full_q : 1'b0);
  assign link_data = is_odd ? even_data_q : odd_data_q;
  assign ptr_sel   = is_odd ? ptr_odd_q : ptr_even_q;

  assign arb_req = (running && !tgt_full) ? req : '0;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IdxW)
  ) u_arb (
    .req_i   (arb_req),
    .ptr_i   (ptr_sel),
    .gnt_o   (arb_gnt),
    .idx_o   (arb_idx),
    .valid_o (wr_en)
  );

  assign grant    = arb_gnt;
  assign wr_data  = data_in[arb_idx*DATA_WIDTH +: DATA_WIDTH];
  assign ptr_next = IdxW'((32'(arb_idx) + 32'd1) % NUM_REQ);

  assign sendO    = link_full & receiveO & running;
  assign dataO    = link_full ? link_data : '0;
  assign polarity = is_odd;

  always_comb begin
    state_d     = next_phase(state_q);
    odd_full_d  = odd_full_q;
    even_full_d = even_full_q;
    odd_data_d  = odd_data_q;
    even_data_d = even_data_q;
    ptr_odd_d   = ptr_odd_q;
    ptr_even_d  = ptr_even_q;

    if (wr_en && is_odd) begin
      odd_full_d = 1'b1;
      odd_data_d = wr_data;
      ptr_odd_d  = ptr_next;
    end
    if (wr_en && is_even) begin
      even_full_d = 1'b1;
      even_data_d = wr_data;
      ptr_even_d  = ptr_next;
    end

    if (sendO && is_odd)  even_full_d = 1'b0;
    if (sendO && is_even) odd_full_d  = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= PHASE_IDLE;
      odd_full_q  <= 1'b0;
      even_full_q <= 1'b0;
      odd_data_q  <= '0;
      even_data_q <= '0;
      ptr_odd_q   <= '0;
      ptr_even_q  <= '0;
    end else begin
      state_q     <= state_d;
      odd_full_q  <= odd_full_d;
      even_full_q <= even_full_d;
      odd_data_q  <= odd_data_d;
      even_data_q <= even_data_d;
      ptr_odd_q   <= ptr_odd_d;
      ptr_even_q  <= ptr_even_d;
    end
  end

endmodule

// File: tb/tb_output_ctrl.sv
// Directed bench for output_ctrl: reset, single flit, round-robin, backpressure, mid-op reset.
module tb_output_ctrl;

  localparam int unsigned DW = 64;
  localparam int unsigned NR = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [NR-1:0]    req;
  logic [NR*DW-1:0] data_in;
  logic [NR-1:0]    grant;
  logic             receiveO;
  logic             sendO;
  logic [DW-1:0]    dataO;
  logic             polarity;

  logic [DW-1:0] sv [NR];
  int vecs = 0;
  int errs = 0;

  output_ctrl #(
    .DATA_WIDTH (DW),
    .NUM_REQ    (NR)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .data_in  (data_in),
    .grant    (grant),
    .receiveO (receiveO),
    .sendO    (sendO),
    .dataO    (dataO),
    .polarity (polarity)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Leaves the bench at a falling edge with the DUT in its first ODD cycle.
  task automatic do_reset();
    rst = 1'b0;
    req = '0;
    receiveO = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    req = 4'hF;
    receiveO = 1'b1;
    step();
    step();
    #1;
    vecs++; if (grant !== 4'h0) begin errs++; $display("FAIL rst_grant got %b exp 0000", grant); end
    vecs++; if (sendO !== 1'b0) begin errs++; $display("FAIL rst_send got %b exp 0", sendO); end
    vecs++; if (dataO !== 64'h0) begin errs++; $display("FAIL rst_data got %h exp 0", dataO); end
    vecs++; if (polarity !== 1'b0) begin errs++; $display("FAIL rst_pol got %b exp 0", polarity); end
    @(negedge clk);
    rst = 1'b1;
    #1;
    vecs++; if (polarity !== 1'b0) begin errs++; $display("FAIL idle_pol got %b exp 0", polarity); end
    vecs++; if (grant !== 4'h0) begin errs++; $display("FAIL idle_grant got %b exp 0000", grant); end
    step();
    #1;
    vecs++; if (polarity !== 1'b1) begin errs++; $display("FAIL odd_pol got %b exp 1", polarity); end
    vecs++; if (grant !== 4'b0001) begin errs++; $display("FAIL odd_grant got %b exp 0001", grant); end
  endtask

  task automatic test_single_flit();
    do_reset();
    req = 4'b0100;
    receiveO = 1'b1;
    #1;
    vecs++; if (grant !== 4'b0100) begin errs++; $display("FAIL sf_grant got %b exp 0100", grant); end
    vecs++; if (sendO !== 1'b0) begin errs++; $display("FAIL sf_send0 got %b exp 0", sendO); end
    step();
    req = '0;
    #1;
    vecs++; if (sendO !== 1'b1) begin errs++; $display("FAIL sf_send got %b exp 1", sendO); end
    vecs++; if (dataO !== 64'hA5A5_A5A5_A5A5_A5A5) begin
      errs++; $display("FAIL sf_data got %h exp a5a5a5a5a5a5a5a5", dataO);
    end
    vecs++; if (polarity !== 1'b0) begin errs++; $display("FAIL sf_pol got %b exp 0", polarity); end
    step();
    #1;
    vecs++; if (sendO !== 1'b0) begin errs++; $display("FAIL sf_after got %b exp 0", sendO); end
    vecs++; if (dataO !== 64'h0) begin errs++; $display("FAIL sf_after_data got %h exp 0", dataO); end
  endtask

  task automatic test_round_robin();
    logic [NR-1:0] exp_g;
    logic [DW-1:0] exp_d;
    do_reset();
    req = 4'hF;
    receiveO = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      exp_g = 4'b0001 << ((i / 2) % 4);
      vecs++; if (grant !== exp_g) begin
        errs++; $display("FAIL rr_grant[%0d] got %b exp %b", i, grant, exp_g);
      end
      if (i > 0) begin
        exp_d = sv[((i - 1) / 2) % 4];
        vecs++; if (sendO !== 1'b1) begin errs++; $display("FAIL rr_send[%0d] got %b exp 1", i, sendO); end
        vecs++; if (dataO !== exp_d) begin
          errs++; $display("FAIL rr_data[%0d] got %h exp %h", i, dataO, exp_d);
        end
      end else begin
        vecs++; if (sendO !== 1'b0) begin errs++; $display("FAIL rr_send[0] got %b exp 0", sendO); end
      end
      step();
    end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] exp_d;
    do_reset();
    req = 4'b0001;
    receiveO = 1'b0;
    #1;
    vecs++; if (grant !== 4'b0001) begin errs++; $display("FAIL bp_fill got %b exp 0001", grant); end
    step();
    req = 4'b0010;
    // c=1 is EVEN (even buffer fills with slice 1); afterwards both buffers stall.
    for (int c = 1; c <= 6; c++) begin
      #1;
      exp_d = (c % 2 == 1) ? sv[0] : sv[1];
      vecs++; if (grant !== ((c == 1) ? 4'b0010 : 4'b0000)) begin
        errs++; $display("FAIL bp_grant[%0d] got %b exp %b", c, grant, (c == 1) ? 4'b0010 : 4'b0000);
      end
      vecs++; if (sendO !== 1'b0) begin errs++; $display("FAIL bp_send[%0d] got %b exp 0", c, sendO); end
      vecs++; if (dataO !== exp_d) begin
        errs++; $display("FAIL bp_data[%0d] got %h exp %h", c, dataO, exp_d);
      end
      step();
    end
    receiveO = 1'b1;
    #1;
    vecs++; if (sendO !== 1'b1) begin errs++; $display("FAIL bp_rel_send got %b exp 1", sendO); end
    vecs++; if (dataO !== sv[0]) begin errs++; $display("FAIL bp_rel_data got %h exp %h", dataO, sv[0]); end
    vecs++; if (grant !== 4'b0000) begin errs++; $display("FAIL bp_rel_grant got %b exp 0000", grant); end
    step();
    #1;
    vecs++; if (grant !== 4'b0010) begin errs++; $display("FAIL bp_resume got %b exp 0010", grant); end
    vecs++; if (dataO !== sv[1]) begin errs++; $display("FAIL bp_even_data got %h exp %h", dataO, sv[1]); end
    step();
  endtask

  task automatic test_reset_midop();
    do_reset();
    req = 4'b0001;
    step();
    req = 4'b0010;
    step();
    req = '0;
    receiveO = 1'b1;
    #1;
    vecs++; if (sendO !== 1'b1) begin errs++; $display("FAIL mr_pre_send got %b exp 1", sendO); end
    vecs++; if (dataO !== sv[1]) begin errs++; $display("FAIL mr_pre_data got %h exp %h", dataO, sv[1]); end
    #1;
    rst = 1'b0;
    #1;
    vecs++; if (sendO !== 1'b0) begin errs++; $display("FAIL mr_send got %b exp 0", sendO); end
    vecs++; if (dataO !== 64'h0) begin errs++; $display("FAIL mr_data got %h exp 0", dataO); end
    vecs++; if (polarity !== 1'b0) begin errs++; $display("FAIL mr_pol got %b exp 0", polarity); end
    @(negedge clk);
    rst = 1'b1;
    step();
    for (int c = 0; c < 2; c++) begin
      #1;
      vecs++; if (sendO !== 1'b0) begin errs++; $display("FAIL mr_stale[%0d] got %b exp 0", c, sendO); end
      step();
    end
    req = 4'b0100;
    #1;
    vecs++; if (grant !== 4'b0100) begin errs++; $display("FAIL mr_grant got %b exp 0100", grant); end
    step();
    req = '0;
    #1;
    vecs++; if (sendO !== 1'b1) begin errs++; $display("FAIL mr_fresh_send got %b exp 1", sendO); end
    vecs++; if (dataO !== sv[2]) begin errs++; $display("FAIL mr_fresh_data got %h exp %h", dataO, sv[2]); end
  endtask

  initial begin
    sv[0] = 64'h0123_4567_89AB_CDEF;
    sv[1] = 64'h1111_2222_3333_4444;
    sv[2] = 64'hA5A5_A5A5_A5A5_A5A5;
    sv[3] = 64'hDEAD_BEEF_CAFE_F00D;
    data_in = {sv[3], sv[2], sv[1], sv[0]};
    rst = 1'b0;
    req = '0;
    receiveO = 1'b0;
    test_reset();
    test_single_flit();
    test_round_robin();
    test_backpressure();
    test_reset_midop();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
